// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronises reset release and PLL lock, stretches reset, then releases domains in staggered order.
// Latency: first domain released SYNC_STAGES+1+STRETCH_CYCLES edges after rst_in falls; domain k follows k*STAGGER edges later.
// Backpressure: none; soft-reset, watchdog and lock-loss events restart the sequence and are recorded in rst_cause.
module rst_sequencer #(
    parameter int N_OUT          = 2,
    parameter int STRETCH_CYCLES = 15,
    parameter int STAGGER        = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int WDT_CYCLES     = 0
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             pll_locked,
    input  logic             soft_rst_req,
    input  logic             wdt_kick,
    output logic [N_OUT-1:0] rst_out,
    output logic             rst_done,
    output logic [1:0]       rst_cause
);

    // Sequence counter is shared by STRETCH and RELEASE; it only has to reach
    // the larger of the two terminal values, so it can never wrap.
    localparam int STR_LAST = STRETCH_CYCLES - 1;
    localparam int REL_LAST = (N_OUT - 1) * STAGGER;
    localparam int CNT_MAX  = (REL_LAST > STR_LAST) ? REL_LAST : STR_LAST;
    localparam int CNT_W    = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam int WDT_W    = (WDT_CYCLES < 1) ? 1 : $clog2(WDT_CYCLES + 1);

    localparam logic [CNT_W-1:0] STR_END = CNT_W'(STR_LAST);
    localparam logic [CNT_W-1:0] REL_END = CNT_W'(REL_LAST);
    localparam logic [WDT_W-1:0] WDT_END = WDT_W'(WDT_CYCLES);
    localparam logic             WDT_ON  = (WDT_CYCLES > 0);

    localparam logic [1:0] CAUSE_EXT  = 2'd0;
    localparam logic [1:0] CAUSE_LOCK = 2'd1;
    localparam logic [1:0] CAUSE_SOFT = 2'd2;
    localparam logic [1:0] CAUSE_WDT  = 2'd3;

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_STRETCH = 2'd1,
        S_RELEASE = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [WDT_W-1:0]   wdt_cnt;
    logic [N_OUT-1:0]   rst_out_nxt;
    logic               rst_done_nxt;
    logic [1:0]         cause_nxt;

    logic [SYNC_STAGES-1:0] rst_chain;
    logic [SYNC_STAGES-1:0] lock_chain;
    logic                   rst_sync;
    logic                   lock_sync;
    logic                   soft_q;
    logic                   wdt_expired;
    logic [N_OUT-1:0]       rel_hit;

    // ------------------------------------------------------------------
    // Synchronisers. rst_in asserts asynchronously but its release, and
    // the lock indication, only reach the FSM after SYNC_STAGES flops.
    // ------------------------------------------------------------------

    // Shift reset-release and lock status through their own chains.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            rst_chain  <= '1;
            lock_chain <= '0;
        end else begin
            rst_chain  <= {rst_chain[SYNC_STAGES-2:0], 1'b0};
            lock_chain <= {lock_chain[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign rst_sync  = rst_chain[SYNC_STAGES-1];
    assign lock_sync = lock_chain[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Event capture. Soft requests are registered so the FSM acts on the
    // edge after sampling; requests outside RUN are dropped here.
    // ------------------------------------------------------------------

    // Register soft-reset request, accepted only while running.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            soft_q <= 1'b0;
        end else begin
            soft_q <= soft_rst_req && (state == S_RUN);
        end
    end

    // Watchdog: counts RUN cycles since the last kick, saturating at the
    // timeout so it cannot wrap. Held at zero outside RUN, which also
    // clears it on entry to RUN.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            wdt_cnt <= '0;
        end else if (!WDT_ON || state != S_RUN || wdt_kick) begin
            wdt_cnt <= '0;
        end else if (wdt_cnt != WDT_END) begin
            wdt_cnt <= wdt_cnt + WDT_W'(1);
        end
    end

    assign wdt_expired = WDT_ON && (wdt_cnt == WDT_END);

    // ------------------------------------------------------------------
    // Stagger decode: domain k (k >= 1) is released on the edge where the
    // RELEASE counter reads k*STAGGER-1, i.e. k*STAGGER edges after
    // domain 0. Domain 0 is released on the STRETCH exit edge.
    // ------------------------------------------------------------------
    assign rel_hit[0] = 1'b0;
    for (genvar g = 1; g < N_OUT; g++) begin : g_rel_hit
        assign rel_hit[g] = (cnt == CNT_W'(g * STAGGER - 1));
    end

    // ------------------------------------------------------------------
    // Sequencing FSM.
    // ------------------------------------------------------------------

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state     <= S_HOLD;
            cnt       <= '0;
            rst_out   <= '1;
            rst_done  <= 1'b0;
            rst_cause <= CAUSE_EXT;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rst_out   <= rst_out_nxt;
            rst_done  <= rst_done_nxt;
            rst_cause <= cause_nxt;
        end
    end

    // Next-state and next-output decode; lock loss overrides everything.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        rst_out_nxt = rst_out;
        cause_nxt   = rst_cause;

        case (state)
            S_HOLD: begin
                rst_out_nxt = '1;
                cnt_nxt     = '0;
                if (!rst_sync && lock_sync) begin
                    state_nxt = S_STRETCH;
                end
            end

            S_STRETCH: begin
                rst_out_nxt = '1;
                if (cnt == STR_END) begin
                    state_nxt      = S_RELEASE;
                    cnt_nxt        = '0;
                    rst_out_nxt[0] = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            S_RELEASE: begin
                rst_out_nxt = rst_out & ~rel_hit;
                if (cnt == REL_END) begin
                    state_nxt   = S_RUN;
                    cnt_nxt     = '0;
                    rst_out_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            S_RUN: begin
                rst_out_nxt = '0;
                cnt_nxt     = '0;
                // Watchdog outranks soft reset; both skip the synchronisers
                // and restart directly in STRETCH.
                if (wdt_expired) begin
                    state_nxt   = S_STRETCH;
                    rst_out_nxt = '1;
                    cause_nxt   = CAUSE_WDT;
                end else if (soft_q) begin
                    state_nxt   = S_STRETCH;
                    rst_out_nxt = '1;
                    cause_nxt   = CAUSE_SOFT;
                end
            end

            default: begin
                state_nxt   = S_HOLD;
                cnt_nxt     = '0;
                rst_out_nxt = '1;
            end
        endcase

        // Losing lock anywhere past HOLD drops every domain back into reset
        // and waits in HOLD for the lock to return.
        if (state != S_HOLD && !lock_sync) begin
            state_nxt   = S_HOLD;
            cnt_nxt     = '0;
            rst_out_nxt = '1;
            cause_nxt   = CAUSE_LOCK;
        end
    end

    assign rst_done_nxt = (state_nxt == S_RUN);

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: scoreboard of per-edge expected outputs, filled from a release-profile table.
// Latency: checks are taken 1 time unit after each rising edge; asynchronous reset checked mid-cycle.
// Backpressure: not applicable; watchdog enabled with an 8-cycle timeout.
module tb_rst_sequencer;

    logic       clk = 1'b0;
    logic       rst_in;
    logic       pll_locked;
    logic       soft_rst_req;
    logic       wdt_kick;
    logic [1:0] rst_out;
    logic       rst_done;
    logic [1:0] rst_cause;

    rst_sequencer #(
        .N_OUT          (2),
        .STRETCH_CYCLES (15),
        .STAGGER        (4),
        .SYNC_STAGES    (2),
        .WDT_CYCLES     (8)
    ) dut (
        .clk          (clk),
        .rst_in       (rst_in),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .wdt_kick     (wdt_kick),
        .rst_out      (rst_out),
        .rst_done     (rst_done),
        .rst_cause    (rst_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         edge_n;
        logic [1:0] out;
        logic       done;
        logic [1:0] cause;
        string      name;
    } exp_t;

    // Release profile relative to the edge on which rst_out[0] clears.
    typedef struct {
        int         off;
        logic [1:0] out;
        logic       done;
    } rel_t;

    exp_t sb[$];
    rel_t prof[5];
    int   edge_cnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic cmp(input string name, input logic [1:0] act, input logic [1:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp_v);
        end
    endtask

    task automatic push(input int t, input logic [1:0] o, input logic d,
                        input logic [1:0] c, input string tag);
        exp_t e;
        int   i;
        e.edge_n = t;
        e.out    = o;
        e.done   = d;
        e.cause  = c;
        e.name   = $sformatf("%s@%0d", tag, t);
        i = 0;
        while (i < sb.size() && sb[i].edge_n <= t) i++;
        sb.insert(i, e);
    endtask

    task automatic push_release(input int t0, input logic [1:0] c, input string tag);
        for (int i = 0; i < 5; i++) begin
            push(t0 + prof[i].off, prof[i].out, prof[i].done, c, tag);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0 && sb[0].edge_n <= edge_cnt) begin
            e = sb.pop_front();
            if (e.edge_n < edge_cnt) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: check skipped at edge %0d", e.name, edge_cnt);
            end else begin
                cmp({e.name, ".rst_out"},   rst_out,          e.out);
                cmp({e.name, ".rst_done"},  {1'b0, rst_done}, {1'b0, e.done});
                cmp({e.name, ".rst_cause"}, rst_cause,        e.cause);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_cnt++;
        #1;
        drain();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_async(input string tag);
        #2;
        cmp({tag, ".rst_out"},   rst_out,          2'b11);
        cmp({tag, ".rst_done"},  {1'b0, rst_done}, 2'b00);
        cmp({tag, ".rst_cause"}, rst_cause,        2'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int e;
        int k;
        int l0;

        prof[0] = '{off: -1, out: 2'b11, done: 1'b0};
        prof[1] = '{off:  0, out: 2'b10, done: 1'b0};
        prof[2] = '{off:  3, out: 2'b10, done: 1'b0};
        prof[3] = '{off:  4, out: 2'b00, done: 1'b0};
        prof[4] = '{off:  5, out: 2'b00, done: 1'b1};

        // Power-on with lock already present.
        rst_in       = 1'b1;
        pll_locked   = 1'b1;
        soft_rst_req = 1'b0;
        wdt_kick     = 1'b1;
        check_async("por_reset");
        run(5);
        rst_in = 1'b0;
        base   = edge_cnt;
        push(base + 1, 2'b11, 1'b0, 2'd0, "por_sync");
        push(base + 3, 2'b11, 1'b0, 2'd0, "por_stretch");
        push_release(base + 18, 2'd0, "por");
        push(base + 25, 2'b00, 1'b1, 2'd0, "por_run");
        run(25);

        // Soft reset in RUN, then an ignored pulse during RELEASE.
        e = edge_cnt + 1;
        push(e,      2'b00, 1'b1, 2'd0, "soft_sampled");
        push(e + 1,  2'b11, 1'b0, 2'd2, "soft_assert");
        push(e + 15, 2'b11, 1'b0, 2'd2, "soft_stretch");
        push_release(e + 16, 2'd2, "soft");
        push(e + 23, 2'b00, 1'b1, 2'd2, "soft_in_release_ignored");
        push(e + 26, 2'b00, 1'b1, 2'd2, "soft_run");
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        run(16);
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        run(9);

        // Watchdog: regular kicks keep it quiet, then let it expire.
        base = edge_cnt;
        for (int i = 0; i < 8; i++) begin
            push(base + 5 * (i + 1), 2'b00, 1'b1, 2'd2, "wdt_kicked");
        end
        for (int i = 0; i < 8; i++) begin
            wdt_kick = 1'b1;
            tick();
            wdt_kick = 1'b0;
            run(4);
        end
        k = edge_cnt + 1;
        push(k + 8, 2'b00, 1'b1, 2'd2, "wdt_not_yet");
        push(k + 9, 2'b11, 1'b0, 2'd3, "wdt_fire");
        push_release(k + 24, 2'd3, "wdt");
        wdt_kick = 1'b1;
        tick();
        wdt_kick = 1'b0;
        run(9);
        wdt_kick = 1'b1;
        run(22);

        // Lock loss in RUN with a soft request seen on the same edge.
        l0 = edge_cnt;
        push(l0 + 2,  2'b00, 1'b1, 2'd3, "lock_sync_lag");
        push(l0 + 3,  2'b11, 1'b0, 2'd1, "lock_loss");
        push(l0 + 12, 2'b11, 1'b0, 2'd1, "lock_hold");
        push(l0 + 27, 2'b11, 1'b0, 2'd1, "relock_stretch");
        push(l0 + 28, 2'b10, 1'b0, 2'd1, "relock_rel0");
        push(l0 + 29, 2'b10, 1'b0, 2'd1, "relock_rel0b");
        pll_locked = 1'b0;
        tick();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        run(8);
        pll_locked = 1'b1;
        run(19);

        // rst_in pulse mid-RELEASE restarts the full sequence.
        rst_in = 1'b1;
        check_async("mid_rst_assert");
        push(edge_cnt + 2, 2'b11, 1'b0, 2'd0, "mid_rst_held");
        run(2);
        rst_in = 1'b0;
        base   = edge_cnt;
        push(base + 17, 2'b11, 1'b0, 2'd0, "mid_rst_stretch");
        push_release(base + 18, 2'd0, "mid_rst");
        run(25);

        // Lock arrives 30 cycles after reset release.
        rst_in     = 1'b1;
        pll_locked = 1'b0;
        check_async("late_reset");
        run(2);
        rst_in = 1'b0;
        base   = edge_cnt;
        push(base + 29, 2'b11, 1'b0, 2'd0, "late_wait");
        push(base + 47, 2'b11, 1'b0, 2'd0, "late_stretch");
        push_release(base + 48, 2'd0, "late");
        run(30);
        pll_locked = 1'b1;
        run(25);

        while (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never reached, run ended at edge %0d", x.name, edge_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
